// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between port 0 (cpu0 control unit)
// and port 1 (DMA/IO master) using a req/ack handshake and a fixed access time
// of WAIT_CYCLES cycles. WAIT_CYCLES must be in 1..15.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise port 0 has fixed priority on simultaneous requests.
// Reset is asynchronous and active-low on the port named 'reset'.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          m_en,
  output logic          m_rw,
  output logic [AW-1:0] mar,
  output logic [DW-1:0] mdr,
  input  logic [DW-1:0] dbus
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            m_en_q, m_en_d;
  logic            m_rw_q, m_rw_d;
  logic [AW-1:0]   mar_q, mar_d;
  logic [DW-1:0]   mdr_q, mdr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            win;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic            rr_ptr_q, rr_ptr_d;
`endif

  // Arbitration: win=1 means port 1 takes the memory this IDLE cycle.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (req0 && req1) begin
      win = ~rr_ptr_q;
    end else begin
      win = req1;
    end
`else
    win = ~req0;
`endif
  end

  // State register and all registered outputs; reset aborts any access at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      m_en_q   <= 1'b0;
      m_rw_q   <= 1'b1;
      mar_q    <= '0;
      mdr_q    <= '0;
      rdata_q  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      m_en_q   <= m_en_d;
      m_rw_q   <= m_rw_d;
      mar_q    <= mar_d;
      mdr_q    <= mdr_d;
      rdata_q  <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> DONE when the count expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 || req1) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computes next values of every registered output from the current state.
  always_comb begin
    cnt_d   = cnt_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    m_en_d  = m_en_q;
    m_rw_d  = m_rw_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_ptr_d = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        if (req0 || req1) begin
          m_en_d = 1'b1;
          gnt0_d = ~win;
          gnt1_d = win;
          m_rw_d = win ? rw1 : rw0;
          mar_d  = win ? addr1 : addr0;
          mdr_d  = win ? wdata1 : wdata0;
          cnt_d  = CNT_INIT;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_ptr_d = win;
`endif
        end else begin
          m_en_d = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          m_en_d = 1'b0;
          if (m_rw_q) rdata_d = dbus;
          ack0_d = gnt0_q;
          ack1_d = gnt1_q;
        end
      end
      DONE: begin
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        m_rw_d = 1'b1;
      end
      default: begin
        ack0_d = 1'b0;
        ack1_d = 1'b0;
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        m_en_d = 1'b0;
        m_rw_d = 1'b1;
      end
    endcase
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rdata = rdata_q;
  assign busy  = (state_q != IDLE);
  assign m_en  = m_en_q;
  assign m_rw  = m_rw_q;
  assign mar   = mar_q;
  assign mdr   = mdr_q;

endmodule
